// File: rtl/nexus_bitset_pkg.sv
// nexus_bitset_pkg
// Shared types and helpers for the two-level occupancy bitset.
//   ffs_lo    : first-set index (lowest bit) plus found flag, for vectors up
//               to 64 bits (narrower callers zero-extend).
//   mask_ge   : thermometer mask with every bit at position >= k set; k may
//               be 64, which yields an all-zero mask.
//   split_idx : splits a bucket index into its group and in-group fields.
package nexus_bitset_pkg;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } ffs_res_t;

  typedef struct packed {
    logic [5:0] grp;
    logic [5:0] bkt;
  } idx_split_t;

  function automatic ffs_res_t ffs_lo(input logic [63:0] vec);
    ffs_res_t r;
    r.found = 1'b0;
    r.idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = 6'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] mask_ge(input logic [6:0] k);
    logic [63:0] m;
    for (int i = 0; i < 64; i++) begin
      m[i] = (7'(i) >= k);
    end
    return m;
  endfunction

  function automatic idx_split_t split_idx(input logic [11:0] idx, input int unsigned l2w);
    idx_split_t s;
    s.grp = 6'(idx >> l2w);
    s.bkt = 6'(idx & ((12'd1 << l2w) - 12'd1));
    return s;
  endfunction

endpackage

// File: rtl/nexus_ffs.sv
// nexus_ffs
// Find-first-set over a W-bit vector restricted to the bits enabled in mask.
// Ports:
//   vec   : candidate bits
//   mask  : qualifying bits (1 = eligible)
//   idx   : position of the lowest eligible set bit (0 when none)
//   found : at least one eligible bit is set
module nexus_ffs
  import nexus_bitset_pkg::*;
#(
  parameter  int W    = 16,
  localparam int IDXW = $clog2(W)
) (
  input  logic [W-1:0]    vec,
  input  logic [W-1:0]    mask,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  ffs_res_t res;

  assign res   = ffs_lo(64'(vec & mask));
  assign found = res.found;
  assign idx   = IDXW'(res.idx);

endmodule

// File: rtl/nexus_hier_bitset.sv
// nexus_hier_bitset
// Two-level occupancy bitset for the PIFO calendar. Tracks which of
// L1_SIZE*L2_SIZE buckets are non-empty and reports a registered best bucket.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_set / i_set_idx      : mark a bucket non-empty
//   i_clr / i_clr_idx      : mark a bucket empty (a same-index set wins)
//   i_base                 : rotating search start (ROTATE=1 only)
//   o_valid / o_empty      : some bucket is / no bucket is non-empty
//   o_best_idx             : lowest (or first at/after base) non-empty bucket
//   o_count                : number of non-empty buckets
// Maps and o_count update at the request edge; the search runs on the
// registered maps and its result is registered one edge later.
module nexus_hier_bitset
  import nexus_bitset_pkg::*;
#(
  parameter  int L1_SIZE = 16,
  parameter  int L2_SIZE = 16,
  parameter  int ROTATE  = 0,
  localparam int IW      = $clog2(L1_SIZE * L2_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_set,
  input  logic [IW-1:0] i_set_idx,
  input  logic          i_clr,
  input  logic [IW-1:0] i_clr_idx,
  input  logic [IW-1:0] i_base,
  output logic          o_valid,
  output logic [IW-1:0] o_best_idx,
  output logic          o_empty,
  output logic [IW:0]   o_count
);

  localparam int L1W = $clog2(L1_SIZE);
  localparam int L2W = $clog2(L2_SIZE);

  // State
  logic [L1_SIZE-1:0][L2_SIZE-1:0] l2_map_reg, l2_map_next;
  logic [L1_SIZE-1:0]              l1_map_reg, l1_map_next;
  logic [IW:0]                     count_reg, count_next;
  logic [IW-1:0]                   base_reg;
  logic                            valid_reg, empty_reg;
  logic [IW-1:0]                   best_reg, best_next;

  // Index fields
  idx_split_t     set_split, clr_split, base_split;
  logic [L1W-1:0] set_grp, clr_grp, base_grp;
  logic [L2W-1:0] set_bkt, clr_bkt, base_bkt;

  assign set_split  = split_idx(12'(i_set_idx), L2W);
  assign clr_split  = split_idx(12'(i_clr_idx), L2W);
  assign base_split = split_idx(12'(base_reg), L2W);
  assign set_grp    = L1W'(set_split.grp);
  assign set_bkt    = L2W'(set_split.bkt);
  assign clr_grp    = L1W'(clr_split.grp);
  assign clr_bkt    = L2W'(clr_split.bkt);
  assign base_grp   = L1W'(base_split.grp);
  assign base_bkt   = L2W'(base_split.bkt);

  // Map update: clear first, then OR in the set so a same-index set wins.
  // The group bit is taken from the post-update word, which covers a clear
  // and set landing in the same group in one cycle.
  for (genvar gi = 0; gi < L1_SIZE; gi++) begin : g_group
    logic [L2_SIZE-1:0] set_vec, clr_vec;
    assign set_vec = (i_set && set_grp == L1W'(gi)) ? (L2_SIZE'(1) << set_bkt) : '0;
    assign clr_vec = (i_clr && clr_grp == L1W'(gi)) ? (L2_SIZE'(1) << clr_bkt) : '0;
    assign l2_map_next[gi] = (l2_map_reg[gi] & ~clr_vec) | set_vec;
    assign l1_map_next[gi] = |l2_map_next[gi];
  end

  // Count only effective transitions so idempotent requests leave it alone.
  logic set_eff, clr_eff, same_idx;
  assign same_idx   = i_set && i_clr && (i_set_idx == i_clr_idx);
  assign set_eff    = i_set && !l2_map_reg[set_grp][set_bkt];
  assign clr_eff    = i_clr && l2_map_reg[clr_grp][clr_bkt] && !same_idx;
  assign count_next = count_reg + (IW+1)'(set_eff) - (IW+1)'(clr_eff);

  // Search. Lowest path: first group, then first bucket in it; this also
  // serves as the wrap path of the rotating search.
  logic [L1W-1:0] lo_grp, hi_grp;
  logic [L2W-1:0] lo_bkt, base_hit_bkt, hi_bkt;
  logic           lo_grp_found, lo_bkt_found;
  logic           base_hit_found, hi_grp_found, hi_bkt_found;

  nexus_ffs #(.W(L1_SIZE)) u_l1_lo (
    .vec   (l1_map_reg),
    .mask  ({L1_SIZE{1'b1}}),
    .idx   (lo_grp),
    .found (lo_grp_found)
  );

  nexus_ffs #(.W(L2_SIZE)) u_l2_lo (
    .vec   (l2_map_reg[lo_grp]),
    .mask  ({L2_SIZE{1'b1}}),
    .idx   (lo_bkt),
    .found (lo_bkt_found)
  );

  // Rotating step 1: buckets at or after the base within the base group.
  nexus_ffs #(.W(L2_SIZE)) u_l2_base (
    .vec   (l2_map_reg[base_grp]),
    .mask  (L2_SIZE'(mask_ge(7'(base_bkt)))),
    .idx   (base_hit_bkt),
    .found (base_hit_found)
  );

  // Rotating step 2: groups strictly after the base group. base_grp+1 may
  // equal L1_SIZE, which mask_ge turns into an empty mask.
  nexus_ffs #(.W(L1_SIZE)) u_l1_hi (
    .vec   (l1_map_reg),
    .mask  (L1_SIZE'(mask_ge(7'(base_grp) + 7'd1))),
    .idx   (hi_grp),
    .found (hi_grp_found)
  );

  nexus_ffs #(.W(L2_SIZE)) u_l2_hi (
    .vec   (l2_map_reg[hi_grp]),
    .mask  ({L2_SIZE{1'b1}}),
    .idx   (hi_bkt),
    .found (hi_bkt_found)
  );

  logic valid_next;
  assign valid_next = lo_grp_found && lo_bkt_found;

  always_comb begin
    best_next = {lo_grp, lo_bkt};
    if (ROTATE != 0) begin
      if (base_hit_found) begin
        best_next = {base_grp, base_hit_bkt};
      end else if (hi_grp_found && hi_bkt_found) begin
        best_next = {hi_grp, hi_bkt};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      l2_map_reg <= '0;
      l1_map_reg <= '0;
      count_reg  <= '0;
      base_reg   <= '0;
      valid_reg  <= 1'b0;
      empty_reg  <= 1'b1;
      best_reg   <= '0;
    end else begin
      l2_map_reg <= l2_map_next;
      l1_map_reg <= l1_map_next;
      count_reg  <= count_next;
      base_reg   <= i_base;
      valid_reg  <= valid_next;
      empty_reg  <= ~valid_next;
      best_reg   <= best_next;
    end
  end

  assign o_valid    = valid_reg;
  assign o_empty    = empty_reg;
  assign o_best_idx = best_reg;
  assign o_count    = count_reg;

endmodule
